// File: rtl/simon_pkg.sv
// Shared widths, FSM encodings and the Simon round function for the Simon128/256 block datapath.
// Used by simon_round and simon_round_engine.
package simon_pkg;

  localparam int WORD_W       = 64;
  localparam int BLOCK_W      = 128;
  localparam int KEY_ADDR_W   = 9;
  localparam int KEY_RD_LAT   = 2;
  localparam int N_ROUNDS_DEF = 72;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // f(x) = (rol1(x) & rol8(x)) ^ rol2(x)
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
    return ({v[WORD_W-2:0], v[WORD_W-1]} & {v[WORD_W-9:0], v[WORD_W-1:WORD_W-8]})
         ^ {v[WORD_W-3:0], v[WORD_W-1:WORD_W-2]};
  endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational Simon128 round, encrypt or decrypt direction.
// Decrypt is the exact inverse of encrypt, so the same subkey undoes one round.
module simon_round
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] k,
  input  logic              dec,
  output logic [WORD_W-1:0] x_nxt,
  output logic [WORD_W-1:0] y_nxt
);

  // NOTE: both outputs are assigned on every path so no latch is inferred.
  always_comb begin
    if (dec) begin
      x_nxt = y;
      y_nxt = x ^ simon_f(y) ^ k;
    end else begin
      x_nxt = y ^ simon_f(x) ^ k;
      y_nxt = x;
    end
  end

endmodule

// File: rtl/simon_round_engine.sv
// Streams 72 subkeys out of key memory and applies one Simon128/256 round per returned key.
// Optional macro SIMON_DECRYPT_EN adds a decrypt path (descending subkey addresses, inverse round).
module simon_round_engine
  import simon_pkg::*;
#(
  parameter int                    N_ROUNDS = N_ROUNDS_DEF,
  parameter logic [KEY_ADDR_W-1:0] KEY_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_compute_start,
  input  logic                  key_mem_full,
  output logic                  key_rd_en,
  output logic [KEY_ADDR_W-1:0] key_addr,
  input  logic [WORD_W-1:0]     key_data,
  input  logic                  key_data_vld,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [BLOCK_W-1:0]    in_block,
  input  logic                  in_decrypt,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [BLOCK_W-1:0]    out_block,
  output logic                  out_abort,
  output logic                  busy
);

  localparam int                CNT_W = $clog2(N_ROUNDS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_ROUNDS - 1);

  state_t                  state;
  logic                    keys_ok;
  logic                    dec_q;
  logic                    dec_in;
  logic [WORD_W-1:0]       x_q, y_q, x_nxt, y_nxt;
  logic [CNT_W-1:0]        rd_cnt, rnd_cnt;
  logic [KEY_RD_LAT-1:0]   rd_pipe;
  logic                    abort;

`ifdef SIMON_DECRYPT_EN
  assign dec_in = in_decrypt;
`else
  logic unused_decrypt;
  assign dec_in         = 1'b0;
  assign unused_decrypt = in_decrypt;
`endif

  function automatic logic [KEY_ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] idx, input logic dec);
    return dec ? KEY_BASE + KEY_ADDR_W'(LAST - idx) : KEY_BASE + KEY_ADDR_W'(idx);
  endfunction

  simon_round u_round (
    .x     (x_q),
    .y     (y_q),
    .k     (key_data),
    .dec   (dec_q),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt)
  );

  assign in_rdy    = (state == IDLE) && keys_ok;
  assign busy      = (state != IDLE);
  assign out_vld   = (state == DONE);
  assign out_block = out_vld ? {x_q, y_q} : '0;
  // A completing transfer in DONE wins over a same-cycle restart of the key schedule.
  assign abort     = key_compute_start && ((state == RUN) || ((state == DONE) && !out_rdy));

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      keys_ok   <= 1'b0;
      dec_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rd_cnt    <= '0;
      rnd_cnt   <= '0;
      rd_pipe   <= '0;
      key_rd_en <= 1'b0;
      key_addr  <= '0;
      out_abort <= 1'b0;
    end else begin
      out_abort <= 1'b0;
      rd_pipe   <= {rd_pipe[KEY_RD_LAT-2:0], key_rd_en};

      if (key_compute_start)  keys_ok <= 1'b0;
      else if (key_mem_full)  keys_ok <= 1'b1;

      if (abort) begin
        // Clearing rd_pipe marks reads already issued as stale.
        state     <= IDLE;
        out_abort <= 1'b1;
        key_rd_en <= 1'b0;
        rd_pipe   <= '0;
      end else begin
        case (state)
          IDLE: if (in_vld && in_rdy) begin
            x_q       <= in_block[BLOCK_W-1:WORD_W];
            y_q       <= in_block[WORD_W-1:0];
            dec_q     <= dec_in;
            rd_cnt    <= '0;
            rnd_cnt   <= '0;
            key_rd_en <= 1'b1;
            key_addr  <= addr_of('0, dec_in);
            state     <= RUN;
          end
          RUN: begin
            if (key_rd_en) begin
              if (rd_cnt == LAST) begin
                key_rd_en <= 1'b0;
              end else begin
                rd_cnt   <= rd_cnt + 1'b1;
                key_addr <= addr_of(rd_cnt + 1'b1, dec_q);
              end
            end
            if (key_data_vld && rd_pipe[KEY_RD_LAT-1]) begin
              x_q     <= x_nxt;
              y_q     <= y_nxt;
              rnd_cnt <= rnd_cnt + 1'b1;
              if (rnd_cnt == LAST) state <= DONE;
            end
          end
          DONE: if (out_rdy) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_round_engine.sv
// Directed bench for simon_round_engine with a 2-cycle key memory model holding the Simon128/256 schedule.
// Decrypt scenario is compiled in only with SIMON_DECRYPT_EN.
module tb_simon_round_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_compute_start, key_mem_full;
  logic         key_rd_en;
  logic [8:0]   key_addr;
  logic [63:0]  key_data;
  logic         key_data_vld;
  logic         in_vld, in_rdy, in_decrypt;
  logic [127:0] in_block;
  logic         out_vld, out_rdy, out_abort, busy;
  logic [127:0] out_block;

  simon_round_engine dut (
    .clk               (clk),
    .rst               (rst),
    .key_compute_start (key_compute_start),
    .key_mem_full      (key_mem_full),
    .key_rd_en         (key_rd_en),
    .key_addr          (key_addr),
    .key_data          (key_data),
    .key_data_vld      (key_data_vld),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_block          (in_block),
    .in_decrypt        (in_decrypt),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_block         (out_block),
    .out_abort         (out_abort),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  int checks = 0;
  int errors = 0;

  logic [63:0] rk [72];
  logic        rd_d1 = 1'b0;
  logic [8:0]  addr_d1 = '0;
  logic [8:0]  addr_log [$];
  int          xfer_cnt = 0;

  // Key memory: read sampled at an edge returns data two cycles later.
  always @(posedge clk) begin
    rd_d1        <= key_rd_en;
    addr_d1      <= key_addr;
    key_data_vld <= rd_d1;
    key_data     <= (addr_d1 < 9'd72) ? rk[addr_d1[6:0]] : 64'd0;
    if (key_rd_en) addr_log.push_back(key_addr);
    if (out_vld && out_rdy) xfer_cnt <= xfer_cnt + 1;
  end

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  task automatic build_keys();
    logic [61:0] z;
    logic [63:0] tmp;
    z = 62'b11010001111001101011011000100000010111000011001010010011101111;
    rk[0] = 64'h0706050403020100;
    rk[1] = 64'h0f0e0d0c0b0a0908;
    rk[2] = 64'h1716151413121110;
    rk[3] = 64'h1f1e1d1c1b1a1918;
    for (int i = 4; i < 72; i++) begin
      tmp   = ror(rk[i-1], 3) ^ rk[i-3];
      tmp   = tmp ^ ror(tmp, 1);
      rk[i] = ~rk[i-4] ^ tmp ^ {63'd0, z[61 - ((i - 4) % 62)]} ^ 64'd3;
    end
  endtask

  logic [127:0] res;
  int           lat;
  logic         ok;

  task automatic apply_reset();
    rst = 1'b1; key_compute_start = 1'b0; key_mem_full = 1'b0;
    in_vld = 1'b0; in_block = '0; in_decrypt = 1'b0; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_keys();
    key_mem_full = 1'b1;
    @(negedge clk);
    key_mem_full = 1'b0;
  endtask

  // Ends at the negedge of the first cycle after the handshake (lat = 1).
  task automatic accept_block(input logic [127:0] blk, input logic dec);
    int t;
    in_vld = 1'b1; in_block = blk; in_decrypt = dec;
    t = 0;
    while (!in_rdy && t < 50) begin @(negedge clk); t++; end
    ok = in_rdy;
    @(negedge clk);
    in_vld = 1'b0;
    lat = 1;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic dec);
    accept_block(blk, dec);
    while (!out_vld && lat < 300) begin @(negedge clk); lat++; end
    res = out_block;
    checks++;
    if (!(ok && out_vld)) begin
      errors++;
      $display("FAIL handshake_timeout accepted=%0b out_vld=%0b want both 1", ok, out_vld);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 7;
    if (key_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_key_rd_en got %0b want 0", key_rd_en); end
    if (key_addr !== 9'd0)   begin errors++; $display("FAIL rst_key_addr got %0d want 0", key_addr); end
    if (in_rdy !== 1'b0)     begin errors++; $display("FAIL rst_in_rdy got %0b want 0", in_rdy); end
    if (out_vld !== 1'b0)    begin errors++; $display("FAIL rst_out_vld got %0b want 0", out_vld); end
    if (out_block !== '0)    begin errors++; $display("FAIL rst_out_block got %h want 0", out_block); end
    if (out_abort !== 1'b0)  begin errors++; $display("FAIL rst_out_abort got %0b want 0", out_abort); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
  endtask

  task automatic test_wait_keys();
    int   n0;
    logic saw_rdy;
    n0 = addr_log.size();
    saw_rdy = 1'b0;
    in_vld = 1'b1; in_block = PT; in_decrypt = 1'b0;
    repeat (6) begin @(negedge clk); saw_rdy |= in_rdy; end
    checks += 2;
    if (saw_rdy !== 1'b0) begin errors++; $display("FAIL nokeys_in_rdy got 1 want 0"); end
    if (addr_log.size() != n0) begin
      errors++; $display("FAIL nokeys_reads got %0d want 0", addr_log.size() - n0);
    end
    load_keys();
    send_block(PT, 1'b0);
    checks++;
    if (res !== CT) begin errors++; $display("FAIL nokeys_result got %h want %h", res, CT); end
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    int n0;
    n0 = addr_log.size();
    send_block(PT, 1'b0);
    checks += 5;
    if (res !== CT) begin errors++; $display("FAIL enc_result got %h want %h", res, CT); end
    if (lat != 75)  begin errors++; $display("FAIL enc_latency got %0d want 75", lat); end
    if (addr_log.size() - n0 != 72) begin
      errors++; $display("FAIL enc_read_count got %0d want 72", addr_log.size() - n0);
    end
    if (addr_log[n0] !== 9'd0) begin errors++; $display("FAIL enc_first_addr got %0d want 0", addr_log[n0]); end
    if (addr_log[addr_log.size()-1] !== 9'd71) begin
      errors++; $display("FAIL enc_last_addr got %0d want 71", addr_log[addr_log.size()-1]);
    end
    @(negedge clk);
    checks += 2;
    if (out_vld !== 1'b0) begin errors++; $display("FAIL enc_out_vld_drop got %0b want 0", out_vld); end
    if (in_rdy !== 1'b1)  begin errors++; $display("FAIL enc_in_rdy_back got %0b want 1", in_rdy); end
  endtask

  task automatic test_backpressure();
    int   x0;
    logic stable, rdy_seen;
    out_rdy = 1'b0;
    x0 = xfer_cnt;
    send_block(PT, 1'b0);
    stable = 1'b1; rdy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_block !== CT || out_vld !== 1'b1) stable = 1'b0;
      rdy_seen |= in_rdy;
    end
    checks += 2;
    if (stable !== 1'b1)   begin errors++; $display("FAIL bp_hold got %h vld=%0b want %h vld=1", out_block, out_vld, CT); end
    if (rdy_seen !== 1'b0) begin errors++; $display("FAIL bp_in_rdy got 1 want 0"); end
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (out_vld !== 1'b0)    begin errors++; $display("FAIL bp_after_vld got %0b want 0", out_vld); end
    if (xfer_cnt - x0 != 1)  begin errors++; $display("FAIL bp_transfers got %0d want 1", xfer_cnt - x0); end
  endtask

  task automatic test_abort();
    logic saw_vld, saw_rdy;
    accept_block(PT, 1'b0);
    repeat (32) @(negedge clk);
    key_compute_start = 1'b1;
    @(negedge clk);
    key_compute_start = 1'b0;
    checks += 4;
    if (out_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got %0b want 1", out_abort); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    if (out_vld !== 1'b0)   begin errors++; $display("FAIL abort_out_vld got %0b want 0", out_vld); end
    if (in_rdy !== 1'b0)    begin errors++; $display("FAIL abort_in_rdy got %0b want 0", in_rdy); end
    @(negedge clk);
    checks++;
    if (out_abort !== 1'b0) begin errors++; $display("FAIL abort_pulse_width got %0b want 0", out_abort); end
    in_vld = 1'b1; in_block = PT;
    saw_vld = 1'b0; saw_rdy = 1'b0;
    repeat (80) begin @(negedge clk); saw_vld |= out_vld; saw_rdy |= in_rdy; end
    in_vld = 1'b0;
    checks += 2;
    if (saw_vld !== 1'b0) begin errors++; $display("FAIL abort_no_result got 1 want 0"); end
    if (saw_rdy !== 1'b0) begin errors++; $display("FAIL abort_keys_invalid got 1 want 0"); end
    load_keys();
    send_block(PT, 1'b0);
    checks++;
    if (res !== CT) begin errors++; $display("FAIL abort_recover got %h want %h", res, CT); end
    @(negedge clk);
  endtask

  task automatic test_rst_midrun();
    logic saw_busy, saw_rdy;
    accept_block(PT, 1'b0);
    repeat (42) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 6;
    if (key_rd_en !== 1'b0) begin errors++; $display("FAIL mrst_key_rd_en got %0b want 0", key_rd_en); end
    if (key_addr !== 9'd0)  begin errors++; $display("FAIL mrst_key_addr got %0d want 0", key_addr); end
    if (out_vld !== 1'b0)   begin errors++; $display("FAIL mrst_out_vld got %0b want 0", out_vld); end
    if (out_block !== '0)   begin errors++; $display("FAIL mrst_out_block got %h want 0", out_block); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mrst_busy got %0b want 0", busy); end
    if (in_rdy !== 1'b0)    begin errors++; $display("FAIL mrst_in_rdy got %0b want 0", in_rdy); end
    saw_busy = 1'b0; saw_rdy = 1'b0;
    repeat (6) begin @(negedge clk); saw_busy |= busy; saw_rdy |= in_rdy; end
    checks += 2;
    if (saw_busy !== 1'b0) begin errors++; $display("FAIL mrst_stale_vld got busy=1 want 0"); end
    if (saw_rdy !== 1'b0)  begin errors++; $display("FAIL mrst_keys_ok got 1 want 0"); end
    load_keys();
    send_block(PT, 1'b0);
    checks++;
    if (res !== CT) begin errors++; $display("FAIL mrst_recover got %h want %h", res, CT); end
    @(negedge clk);
  endtask

`ifdef SIMON_DECRYPT_EN
  task automatic test_decrypt();
    int n0;
    n0 = addr_log.size();
    send_block(CT, 1'b1);
    checks += 3;
    if (res !== PT) begin errors++; $display("FAIL dec_result got %h want %h", res, PT); end
    if (addr_log[n0] !== 9'd71) begin errors++; $display("FAIL dec_first_addr got %0d want 71", addr_log[n0]); end
    if (addr_log[addr_log.size()-1] !== 9'd0) begin
      errors++; $display("FAIL dec_last_addr got %0d want 0", addr_log[addr_log.size()-1]);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    build_keys();
    @(negedge clk);
    test_reset();
    test_wait_keys();
    test_encrypt();
    test_backpressure();
    test_abort();
    test_rst_midrun();
`ifdef SIMON_DECRYPT_EN
    test_decrypt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
